// File: rtl/bird_io_responder_if.sv
// CPU/RAM memory bus seen by the bird I/O responder.
// The master side is the CPU plus the external RAM read port; the slave side
// is the responder, which decodes the access and steers read data.
interface bird_io_responder_if;
    logic [11:0] address;
    logic [15:0] cpu_wdata;
    logic        memwt;
    logic [15:0] ram_rdata;
    logic        ram_we;
    logic [15:0] cpu_rdata;

    modport master (
        output address,
        output cpu_wdata,
        output memwt,
        output ram_rdata,
        input  ram_we,
        input  cpu_rdata
    );

    modport slave (
        input  address,
        input  cpu_wdata,
        input  memwt,
        input  ram_rdata,
        output ram_we,
        output cpu_rdata
    );
endinterface

// File: rtl/bird_io_responder.sv
// Bus responder for the bird CPU: passes ordinary accesses to external RAM and
// serves a 16-word polled I/O window (buttons, switches, LED, display, timer).
// Read data is combinational because the CPU samples it on the state-ending edge.
module bird_io_responder #(
    parameter logic [11:0] IO_BASE   = 12'hF00,
    parameter int unsigned PRESC_DIV = 50000,
    parameter int unsigned DB_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    bird_io_responder_if.slave  bus,
    input  logic [3:0]          btn,
    input  logic [7:0]          sw,
    output logic [7:0]          led,
    output logic [15:0]         disp
);

    typedef enum logic [3:0] {
        REG_STATUS  = 4'd0,
        REG_SW      = 4'd1,
        REG_LED     = 4'd2,
        REG_DISP    = 4'd3,
        REG_TPERIOD = 4'd4,
        REG_TCOUNT  = 4'd5,
        REG_EVCNT   = 4'd6
    } reg_off_e;

    localparam int unsigned PW = $clog2(PRESC_DIV);
    localparam int unsigned DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);

    logic          io_sel;
    logic          wr_en;
    logic          wr_status;
    logic          wr_led;
    logic          wr_disp;
    logic          wr_tperiod;
    logic          wr_evcnt;

    logic [3:0]    btn_s1;
    logic [3:0]    btn_s2;
    logic [7:0]    sw_s1;
    logic [7:0]    sw_s2;

    logic [3:0]    db_level;
    logic [DW-1:0] db_cnt [4];
    logic [3:0]    db_flip;
    logic [3:0]    db_rise;
    logic          any_event;

    logic [PW-1:0] presc;
    logic          pulse;
    logic [15:0]   tperiod;
    logic [15:0]   tcount;
    logic          tick_set;

    logic [4:0]    status;
    logic [4:0]    status_clr;
    logic [15:0]   evcnt;

    // Address decode and per-register write strobes
    assign io_sel      = (bus.address[11:4] == IO_BASE[11:4]);
    assign wr_en       = bus.memwt & io_sel;
    assign bus.ram_we  = bus.memwt & ~io_sel;
    assign wr_status   = wr_en && (bus.address[3:0] == REG_STATUS);
    assign wr_led      = wr_en && (bus.address[3:0] == REG_LED);
    assign wr_disp     = wr_en && (bus.address[3:0] == REG_DISP);
    assign wr_tperiod  = wr_en && (bus.address[3:0] == REG_TPERIOD);
    assign wr_evcnt    = wr_en && (bus.address[3:0] == REG_EVCNT);

    // Two-flop synchronisers for the raw button and switch inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
        end
    end

    // A button flips on the cycle its mismatch has lasted DB_CYCLES cycles
    always_comb begin
        db_flip = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            db_flip[i] = (btn_s2[i] != db_level[i]) && (db_cnt[i] == DB_LAST);
        end
    end

    assign db_rise   = db_flip & btn_s2;
    assign any_event = |db_rise;

    // Per-button debounce counters and accepted levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (btn_s2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_flip[i]) begin
                    db_level[i] <= btn_s2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign pulse    = (presc == PRESC_LAST);
    // A TPERIOD write pre-empts any pulse landing on the same edge
    assign tick_set = !wr_tperiod && pulse && (tperiod != '0) && (tcount == 16'd1);

    // Prescaler and reloading down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc   <= '0;
            tperiod <= '0;
            tcount  <= '0;
        end else if (wr_tperiod) begin
            presc   <= '0;
            tperiod <= bus.cpu_wdata;
            tcount  <= bus.cpu_wdata;
        end else begin
            presc <= pulse ? '0 : presc + 1'b1;
            if (pulse && (tperiod != '0)) begin
                tcount <= (tcount == 16'd1) ? tperiod : tcount - 16'd1;
            end
        end
    end

    assign status_clr = wr_status ? bus.cpu_wdata[4:0] : '0;

    // Sticky status flags: clear is applied first so a same-cycle set wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= '0;
        end else begin
            status <= (status & ~status_clr) | {tick_set, db_rise};
        end
    end

    // Saturating button-event counter; a write clears it ahead of any increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evcnt <= '0;
        end else if (wr_evcnt) begin
            evcnt <= '0;
        end else if (any_event && (evcnt != '1)) begin
            evcnt <= evcnt + 16'd1;
        end
    end

    // CPU-writable output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led  <= '0;
            disp <= '0;
        end else begin
            if (wr_led) begin
                led <= bus.cpu_wdata[7:0];
            end
            if (wr_disp) begin
                disp <= bus.cpu_wdata;
            end
        end
    end

    // Read path: RAM data outside the window, register map inside it
    always_comb begin
        bus.cpu_rdata = bus.ram_rdata;
        if (io_sel) begin
            case (bus.address[3:0])
                REG_STATUS:  bus.cpu_rdata = {11'b0, status};
                REG_SW:      bus.cpu_rdata = {8'b0, sw_s2};
                REG_LED:     bus.cpu_rdata = {8'b0, led};
                REG_DISP:    bus.cpu_rdata = disp;
                REG_TPERIOD: bus.cpu_rdata = tperiod;
                REG_TCOUNT:  bus.cpu_rdata = tcount;
                REG_EVCNT:   bus.cpu_rdata = evcnt;
                default:     bus.cpu_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bird_io_responder.sv
// Self-checking bench for bird_io_responder with short debounce and prescaler.
module tb_bird_io_responder;

    localparam int DB = 4;
    localparam int PD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  btn;
    logic [7:0]  sw;
    logic [7:0]  led;
    logic [15:0] disp;

    int total = 0;
    int bad   = 0;

    // Reference model of the register file, updated from the register rules
    logic [4:0]  m_status;
    logic [7:0]  m_sw;
    logic [7:0]  m_led;
    logic [15:0] m_disp;
    logic [15:0] m_tperiod;
    logic [15:0] m_tcount;
    logic [15:0] m_evcnt;

    bird_io_responder_if bus ();

    bird_io_responder #(
        .IO_BASE   (12'hF00),
        .PRESC_DIV (PD),
        .DB_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .btn   (btn),
        .sw    (sw),
        .led   (led),
        .disp  (disp)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_read(input logic [3:0] off);
        case (off)
            4'd0:    return {11'b0, m_status};
            4'd1:    return {8'b0, m_sw};
            4'd2:    return {8'b0, m_led};
            4'd3:    return m_disp;
            4'd4:    return m_tperiod;
            4'd5:    return m_tcount;
            4'd6:    return m_evcnt;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [15:0] d);
        bus.address   = a;
        bus.cpu_wdata = d;
        bus.memwt     = 1'b1;
        step();
        bus.memwt     = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [15:0] v);
        bus.address = a;
        bus.memwt   = 1'b0;
        #1;
        v = bus.cpu_rdata;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        rst_n = 1'b0;
        btn = '0; sw = '0;
        bus.address = '0; bus.cpu_wdata = '0; bus.memwt = 1'b0; bus.ram_rdata = '0;
        repeat (3) step();
        rst_n = 1'b1;
        m_status = '0; m_sw = '0; m_led = '0; m_disp = '0;
        m_tperiod = '0; m_tcount = '0; m_evcnt = '0;
        step();
        total++; if (led !== 8'h00) begin bad++; $display("FAIL reset_led got=%h exp=00", led); end
        total++; if (disp !== 16'h0000) begin bad++; $display("FAIL reset_disp got=%h exp=0000", disp); end
        total++; if (bus.ram_we !== 1'b0) begin bad++; $display("FAIL reset_ram_we got=%b exp=0", bus.ram_we); end
        for (int o = 0; o < 7; o++) begin
            rd(12'hF00 + 12'(o), v);
            total++;
            if (v !== 16'h0000) begin bad++; $display("FAIL reset_reg%0d got=%h exp=0000", o, v); end
            step();
        end
    endtask

    task automatic test_decode();
        logic [15:0] r;
        logic [11:0] a;
        logic        we;
        bus.address = 12'h010; bus.cpu_wdata = 16'h1234; bus.memwt = 1'b1;
        bus.ram_rdata = 16'($urandom);
        #1;
        total++; if (bus.ram_we !== 1'b1) begin bad++; $display("FAIL dec_ram_we got=%b exp=1", bus.ram_we); end
        step();
        bus.memwt = 1'b0;
        bus.ram_rdata = 16'h1234;
        #1;
        total++; if (bus.cpu_rdata !== 16'h1234) begin bad++; $display("FAIL dec_ram_read got=%h exp=1234", bus.cpu_rdata); end
        bus.address = 12'hF02; bus.cpu_wdata = 16'h1234; bus.memwt = 1'b1;
        #1;
        total++; if (bus.ram_we !== 1'b0) begin bad++; $display("FAIL dec_io_ram_we got=%b exp=0", bus.ram_we); end
        step();
        bus.memwt = 1'b0;
        m_led = 8'h34;
        total++; if (led !== 8'h34) begin bad++; $display("FAIL dec_led got=%h exp=34", led); end
        // random RAM-side traffic, including the addresses bordering the window
        for (int i = 0; i < 24; i++) begin
            if (i == 0) a = 12'hEFF;
            else if (i == 1) a = 12'hF10;
            else begin
                a = 12'($urandom);
                while (a[11:4] == 8'hF0) a = 12'($urandom);
            end
            we = 1'($urandom);
            r  = 16'($urandom);
            bus.address = a; bus.memwt = we; bus.cpu_wdata = 16'($urandom); bus.ram_rdata = r;
            #1;
            total++; if (bus.ram_we !== we) begin bad++; $display("FAIL dec_rand_we a=%h got=%b exp=%b", a, bus.ram_we, we); end
            total++; if (bus.cpu_rdata !== r) begin bad++; $display("FAIL dec_rand_rd a=%h got=%h exp=%h", a, bus.cpu_rdata, r); end
            step();
        end
        bus.memwt = 1'b0;
        total++; if (led !== m_led) begin bad++; $display("FAIL dec_led_kept got=%h exp=%h", led, m_led); end
    endtask

    task automatic test_regs();
        logic [15:0] v;
        logic [15:0] d;
        logic [3:0]  off;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                sw = 8'($urandom);
                m_sw = sw;
                step(); step();
            end
            off = 4'($urandom);
            d   = 16'($urandom);
            if (off != 4'd4 && $urandom_range(0, 1) == 1) begin
                wr(12'hF00 | {8'h0, off}, d);
                case (off)
                    4'd0: m_status = m_status & ~d[4:0];
                    4'd2: m_led = d[7:0];
                    4'd3: m_disp = d;
                    4'd6: m_evcnt = '0;
                    default: ;
                endcase
            end else begin
                step();
            end
            bus.ram_rdata = 16'($urandom);
            rd(12'hF00 | {8'h0, off}, v);
            total++;
            if (v !== exp_read(off)) begin bad++; $display("FAIL regs_rd off=%0d got=%h exp=%h", off, v, exp_read(off)); end
        end
        total++; if (led !== m_led) begin bad++; $display("FAIL regs_led got=%h exp=%h", led, m_led); end
        total++; if (disp !== m_disp) begin bad++; $display("FAIL regs_disp got=%h exp=%h", disp, m_disp); end
    endtask

    task automatic test_unmapped();
        logic [15:0] v;
        for (int o = 7; o < 16; o++) begin
            bus.ram_rdata = 16'hFFFF;
            rd(12'hF00 + 12'(o), v);
            total++; if (v !== 16'h0000) begin bad++; $display("FAIL unmapped off=%0d got=%h exp=0000", o, v); end
            step();
        end
    endtask

    task automatic test_debounce();
        logic [15:0] v;
        int          b;
        int          len;
        btn = 4'b0100;
        repeat (3) step();
        btn = '0;
        repeat (12) step();
        rd(12'hF00, v);
        total++; if (v !== 16'h0000) begin bad++; $display("FAIL db_glitch_status got=%h exp=0000", v); end
        rd(12'hF06, v);
        total++; if (v !== m_evcnt) begin bad++; $display("FAIL db_glitch_evcnt got=%h exp=%h", v, m_evcnt); end
        for (int i = 0; i < 6; i++) begin
            b   = $urandom_range(0, 3);
            len = $urandom_range(1, DB - 1);
            btn = 4'(1 << b);
            repeat (len) step();
            btn = '0;
            repeat (DB + 4) step();
            rd(12'hF00, v);
            total++; if (v !== 16'h0000) begin bad++; $display("FAIL db_rand_glitch b=%0d len=%0d got=%h exp=0000", b, len, v); end
        end
        btn = 4'b0100;
        repeat (DB) step();
        rd(12'hF00, v);
        total++; if (v !== 16'h0000) begin bad++; $display("FAIL db_early got=%h exp=0000", v); end
        repeat (3) step();
        m_status[2] = 1'b1;
        m_evcnt = m_evcnt + 16'd1;
        rd(12'hF00, v);
        total++; if (v !== 16'h0004) begin bad++; $display("FAIL db_status got=%h exp=0004", v); end
        rd(12'hF06, v);
        total++; if (v !== m_evcnt) begin bad++; $display("FAIL db_evcnt got=%h exp=%h", v, m_evcnt); end
        wr(12'hF00, 16'h0004);
        m_status[2] = 1'b0;
        btn = '0;
        repeat (DB + 4) step();
        rd(12'hF00, v);
        total++; if (v !== 16'h0000) begin bad++; $display("FAIL db_release got=%h exp=0000", v); end
        rd(12'hF06, v);
        total++; if (v !== m_evcnt) begin bad++; $display("FAIL db_release_evcnt got=%h exp=%h", v, m_evcnt); end
    endtask

    task automatic test_w1c_race();
        logic [15:0] v;
        btn = 4'b0001;
        repeat (DB + 4) step();
        btn = '0;
        repeat (DB + 4) step();
        m_status[0] = 1'b1;
        m_evcnt = m_evcnt + 16'd1;
        rd(12'hF00, v);
        total++; if (v !== 16'h0001) begin bad++; $display("FAIL race_pend got=%h exp=0001", v); end
        // the new event lands on edge DB+2 after the press, same edge as the clear
        btn = 4'b0001;
        repeat (DB + 1) step();
        wr(12'hF00, 16'h0001);
        m_evcnt = m_evcnt + 16'd1;
        rd(12'hF00, v);
        total++; if (v !== 16'h0001) begin bad++; $display("FAIL race_w1c got=%h exp=0001", v); end
        rd(12'hF06, v);
        total++; if (v !== m_evcnt) begin bad++; $display("FAIL race_evcnt got=%h exp=%h", v, m_evcnt); end
        step();
        wr(12'hF00, 16'h0001);
        rd(12'hF00, v);
        total++; if (v !== 16'h0000) begin bad++; $display("FAIL race_clear got=%h exp=0000", v); end
        btn = '0;
        repeat (DB + 4) step();
        // EVCNT clear coinciding with a button-1 event
        btn = 4'b0010;
        repeat (DB + 1) step();
        wr(12'hF06, 16'($urandom));
        m_evcnt = '0;
        rd(12'hF06, v);
        total++; if (v !== 16'h0000) begin bad++; $display("FAIL race_evclr got=%h exp=0000", v); end
        rd(12'hF00, v);
        total++; if (v !== 16'h0002) begin bad++; $display("FAIL race_evclr_status got=%h exp=0002", v); end
        btn = '0;
        wr(12'hF00, 16'h001F);
        repeat (DB + 4) step();
    endtask

    task automatic test_timer();
        logic [15:0] v;
        logic [15:0] p;
        int          n;
        logic        exp_tick;
        for (int rep = 0; rep < 3; rep++) begin
            p = 16'($urandom_range(1, 5));
            n = int'(p) * PD;
            wr(12'hF04, p);
            rd(12'hF04, v);
            total++; if (v !== p) begin bad++; $display("FAIL tmr_period got=%h exp=%h", v, p); end
            for (int k = 1; k <= 2 * n; k++) begin
                if (k == n + 1) wr(12'hF00, 16'h0010);
                else step();
                exp_tick = (k == n) || (k == 2 * n);
                rd(12'hF00, v);
                total++;
                if (v[4] !== exp_tick) begin bad++; $display("FAIL tmr_tick p=%0d k=%0d got=%b exp=%b", p, k, v[4], exp_tick); end
                rd(12'hF05, v);
                total++;
                if (v !== p - 16'((k / PD) % int'(p))) begin
                    bad++; $display("FAIL tmr_tcount p=%0d k=%0d got=%h exp=%h", p, k, v, p - 16'((k / PD) % int'(p)));
                end
            end
            wr(12'hF00, 16'h0010);
        end
        wr(12'hF04, 16'd7);
        wr(12'hF05, 16'($urandom));
        rd(12'hF05, v);
        total++; if (v !== 16'd7) begin bad++; $display("FAIL tmr_ro got=%h exp=0007", v); end
        wr(12'hF04, 16'd0);
        for (int k = 0; k < 30; k++) begin
            step();
            rd(12'hF05, v);
            if (k % 10 == 9) begin
                total++; if (v !== 16'd0) begin bad++; $display("FAIL tmr_stop_tcount k=%0d got=%h exp=0000", k, v); end
            end
        end
        rd(12'hF00, v);
        total++; if (v !== 16'h0000) begin bad++; $display("FAIL tmr_stop_tick got=%h exp=0000", v); end
    endtask

    task automatic test_async_reset();
        logic [15:0] v;
        wr(12'hF02, 16'h00AA);
        wr(12'hF04, 16'd1);
        repeat (3) step();
        rd(12'hF00, v);
        total++; if (v !== 16'h0010) begin bad++; $display("FAIL ar_pre_tick got=%h exp=0010", v); end
        total++; if (led !== 8'hAA) begin bad++; $display("FAIL ar_pre_led got=%h exp=aa", led); end
        step();
        rst_n = 1'b0;
        #1;
        total++; if (led !== 8'h00) begin bad++; $display("FAIL ar_led got=%h exp=00", led); end
        rd(12'hF00, v);
        total++; if (v !== 16'h0000) begin bad++; $display("FAIL ar_status got=%h exp=0000", v); end
        rd(12'hF05, v);
        total++; if (v !== 16'h0000) begin bad++; $display("FAIL ar_tcount got=%h exp=0000", v); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_decode();
        test_regs();
        test_unmapped();
        test_debounce();
        test_w1c_race();
        test_timer();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
